// File: rtl/collatz_range.sv
// Purpose: evaluate Collatz counts for RAM_WORDS consecutive start values and store them in a RAM.
// Latency: one RUN edge per sequence value (min one per start value); readback one cycle after the offset.
// Backpressure: none; go is honoured only in IDLE and ignored while a run is active.
module collatz_range #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [31:0] start,
    output logic        done,
    output logic [15:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state_q, state_d;
    logic [31:0]              base_q, base_d;
    logic [31:0]              n_q, n_d;
    logic [15:0]              iter_q, iter_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     done_q, done_d;
    logic [15:0]              count_q, count_d;

    logic [15:0]              mem [RAM_WORDS];
    logic                     ram_we;
    logic [15:0]              ram_wdat;
    logic                     wr_cond;
    logic [RAM_ADDR_BITS-1:0] rd_addr;

    // A value is finished once it reaches 1, collapses to 0 through wrap, or saturates the counter.
    assign wr_cond = (n_q == 32'd1) || (n_q == 32'd0) || (iter_q == 16'hFFFF);
    assign rd_addr = start[RAM_ADDR_BITS-1:0];

    // Next-state logic: IDLE serves readback and accepts go; RUN steps or writes once per edge.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        n_d      = n_q;
        iter_d   = iter_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        count_d  = count_q;
        ram_we   = 1'b0;
        ram_wdat = iter_q;

        case (state_q)
            IDLE: begin
                // Readback uses the RAM contents before any write of a run started this edge.
                count_d = mem[rd_addr];
                if (go) begin
                    base_d  = start;
                    n_d     = start;
                    iter_d  = 16'd1;
                    addr_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wr_cond) begin
                    ram_we   = 1'b1;
                    ram_wdat = (n_q == 32'd0) ? 16'd0 : iter_q;
                    n_d      = base_q + 32'(addr_q) + 32'd1;
                    iter_d   = 16'd1;
                    addr_d   = addr_q + RAM_ADDR_BITS'(1);
                    if (addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    n_d    = n_q[0] ? (n_q * 32'd3 + 32'd1) : (n_q >> 1);
                    iter_d = iter_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset wins over go and over any in-flight run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            n_q     <= '0;
            iter_q  <= 16'd1;
            addr_q  <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            iter_q  <= iter_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // Result RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            mem[addr_q] <= ram_wdat;
        end
    end

    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_collatz_range.sv
// Directed bench: a 4-word instance for timing/edge cases and a default instance for long runs.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
// Expected counts and run lengths are hand-derived from the Collatz sequences involved.
module tb_collatz_range;

    logic        clk;
    logic        s_reset, s_go, s_done;
    logic [31:0] s_start;
    logic [15:0] s_count;
    logic        b_reset, b_go, b_done;
    logic [31:0] b_start;
    logic [15:0] b_count;

    int n_cmp;
    int n_bad;
    int pulses, p1, p2, jb;
    bit seen;

    collatz_range #(.RAM_WORDS(4), .RAM_ADDR_BITS(2)) u_small (
        .clk   (clk),
        .reset (s_reset),
        .go    (s_go),
        .start (s_start),
        .done  (s_done),
        .count (s_count)
    );

    collatz_range u_big (
        .clk   (clk),
        .reset (b_reset),
        .go    (b_go),
        .start (b_start),
        .done  (b_done),
        .count (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rb_small(input int off, input logic [15:0] exp);
        @(negedge clk);
        s_start = 32'(off);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("small readback[%0d]", off), 32'(s_count), 32'(exp));
    endtask

    task automatic rb_big(input int off, input logic [15:0] exp);
        @(negedge clk);
        b_start = 32'(off);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("big readback[%0d]", off), 32'(b_count), 32'(exp));
    endtask

    // One run on the small instance: measures edges from go acceptance to done and the pulse width.
    task automatic run_small(input logic [31:0] st, input int exp_s, input int force_at,
                             input bit chk_hold, input logic [15:0] exp_hold, input string tag);
        int  j;
        bit  got_done;
        @(negedge clk);
        s_start = st;
        s_go    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_go    = 1'b0;
        s_start = 32'hDEAD_BEEF;
        if (chk_hold) chk({tag, " count at go"}, 32'(s_count), 32'(exp_hold));
        j        = 0;
        got_done = 1'b0;
        while (!got_done && j < 1000) begin
            if (force_at != 0 && j == force_at) begin
                force u_small.iter_q = 16'hFFFE;
                #1;
                release u_small.iter_q;
            end
            @(posedge clk);
            j++;
            @(negedge clk);
            if (s_done) got_done = 1'b1;
            if (chk_hold && j == 3) chk({tag, " count held in run"}, 32'(s_count), 32'(exp_hold));
        end
        chk({tag, " edges to done"}, 32'(j), 32'(exp_s));
        @(posedge clk);
        @(negedge clk);
        chk({tag, " done width"}, 32'(s_done), 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        s_reset = 1'b1;
        b_reset = 1'b1;
        s_go    = 1'b0;
        b_go    = 1'b0;
        s_start = '0;
        b_start = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("small reset count", 32'(s_count), 32'd0);
        chk("small reset done", 32'(s_done), 32'd0);
        chk("big reset count", 32'(b_count), 32'd0);
        chk("big reset done", 32'(b_done), 32'd0);
        s_reset = 1'b0;
        b_reset = 1'b0;

        // Values 1..4: counts 1,2,8,3 -> 14 edges
        run_small(32'd1, 14, 0, 1'b0, 16'd0, "run1");
        rb_small(0, 16'd1);
        rb_small(1, 16'd2);
        rb_small(2, 16'd8);
        rb_small(3, 16'd3);

        // Values 0..3: counts 0,1,2,8 -> 1+1+2+8 = 12 edges; go edge reads old RAM[0]=1
        run_small(32'd0, 12, 0, 1'b1, 16'd1, "run0");
        rb_small(0, 16'd0);
        rb_small(1, 16'd1);
        rb_small(2, 16'd2);
        rb_small(3, 16'd8);

        // Go together with readback of offset 2: count takes old RAM[2]=2 and holds it.
        // Values 2..5: counts 2,8,3,6 -> 19 edges
        run_small(32'd2, 19, 0, 1'b1, 16'd2, "run2");
        rb_small(2, 16'd3);
        rb_small(3, 16'd6);

        // go held high throughout, start scrambled while running: done after 14, restart at
        // the first IDLE edge, second done after 15+14 = 29, then go drops.
        pulses = 0;
        p1     = 0;
        p2     = 0;
        @(negedge clk);
        s_start = 32'd1;
        s_go    = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_done) begin
                pulses++;
                if (pulses == 1) p1 = j;
                else if (pulses == 2) begin
                    p2   = j;
                    s_go = 1'b0;
                end
            end
            s_start = (j == 14) ? 32'd1 : $urandom;
        end
        s_go = 1'b0;
        chk("held go pulses", 32'(pulses), 32'd2);
        chk("held go first done", 32'(p1), 32'd14);
        chk("held go second done", 32'(p2), 32'd29);
        rb_small(0, 16'd1);
        rb_small(1, 16'd2);
        rb_small(2, 16'd8);
        rb_small(3, 16'd3);

        // Saturation: value 3 has iter pushed to 0xFFFE after its first step; next step makes
        // 0xFFFF, then it is written as 0xFFFF. Edges: 1 + 2 + 3 + 3 = 9.
        run_small(32'd1, 9, 4, 1'b1, 16'd2, "sat");
        rb_small(2, 16'hFFFF);
        rb_small(3, 16'd3);
        rb_small(0, 16'd1);

        // Reset at edge k+5 mid-run: count cleared (was holding 2), done never pulses.
        @(negedge clk);
        s_start = 32'd1;
        s_go    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_go = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        s_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrun reset count", 32'(s_count), 32'd0);
        chk("midrun reset done", 32'(s_done), 32'd0);
        s_reset = 1'b0;
        pulses  = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (s_done) pulses++;
        end
        chk("midrun reset no done", 32'(pulses), 32'd0);
        run_small(32'd1, 14, 0, 1'b0, 16'd0, "rerun");
        rb_small(2, 16'd8);
        rb_small(3, 16'd3);

        // Default instance, values 1..256
        @(negedge clk);
        b_start = 32'd1;
        b_go    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_go = 1'b0;
        seen = 1'b0;
        jb   = 0;
        while (!seen && jb < 40000) begin
            @(posedge clk);
            jb++;
            @(negedge clk);
            if (b_done) seen = 1'b1;
        end
        chk("big run done seen", 32'(seen), 32'd1);
        rb_big(26, 16'd112);
        rb_big(0, 16'd1);
        rb_big(255, 16'd9);
        rb_big(6, 16'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/collatz_range.md
COLLATZ_RANGE -- requirements
Module: collatz_range

Interface
REQ-001: Parameter RAM_WORDS, default 256, number of consecutive start values evaluated per run and RAM depth.
REQ-002: Parameter RAM_ADDR_BITS, default 8, RAM address width; RAM_WORDS SHALL equal 2**RAM_ADDR_BITS.
REQ-003: clk  input  1  single system clock; all state updates on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: go  input  1  run request, sampled each edge; honoured only in IDLE.
REQ-006: start  input  32  first start value when go is accepted; RAM readback offset (start[RAM_ADDR_BITS-1:0]) while IDLE.
REQ-007: done  output  1  one-cycle pulse marking run completion.
REQ-008: count  output  16  registered readback of the stored Collatz count at the selected offset.

Function
REQ-009: The FSM SHALL have exactly two states, IDLE and RUN.
REQ-010: In IDLE with go=1 at edge k, the block SHALL latch base=start, n=start, iter=1 and addr=0, then enter RUN.
REQ-011: In RUN, each edge SHALL perform exactly one action: a step or a write.
REQ-012: Write condition: n==1, n==0, or iter==16'hFFFF.
REQ-013: Step (write condition false): n <= n>>1 if n even, else n <= 3n+1 truncated to 32 bits (mod 2^32); iter <= iter+1.
REQ-014: Write (write condition true): RAM[addr] <= iter, except n==0 writes 0; then n <= base+addr+1 (32-bit wrap), iter <= 1, addr <= addr+1.
REQ-015: The write with addr==RAM_WORDS-1 SHALL return the FSM to IDLE and set done for the following cycle only.
REQ-016: Count semantics: number of sequence values including start and the final 1 (start 1 -> 1, start 3 -> 8).
REQ-017: Timing: a value with stored count c consumes exactly c RUN edges.
REQ-018: The last write occurs at edge k+S, where S is the sum over all RAM_WORDS values of max(c,1); done is high from edge k+S to edge k+S+1.
REQ-019: A value reaching iter==16'hFFFF without reaching 1 SHALL store 16'hFFFF and advance to the next value; this is the saturation guarantee.
REQ-020: go in RUN SHALL be ignored; start changes in RUN SHALL NOT affect the run.
REQ-021: go held high across the return to IDLE SHALL start a new run at the first IDLE edge.
REQ-022: In IDLE, count <= RAM[start[RAM_ADDR_BITS-1:0]] every edge (one-cycle read latency).
REQ-023: In RUN, count SHALL hold its last value.
REQ-024: RAM SHALL be a single inferred synchronous RAM, RAM_WORDS x 16.
REQ-025: Simultaneous go and readback in IDLE: go wins for state; count still updates from the old RAM contents that edge.

Reset
REQ-026: reset=1 at an edge SHALL force IDLE, done=0, count=0, addr=0, iter=1, n=0, from any state including mid-run.
REQ-027: RAM contents are not cleared by reset and SHALL be treated as undefined until a run completes.
REQ-028: reset has priority over go at the same edge.

Verification
REQ-029: Run RAM_WORDS=4, start=1, go pulse at edge k -> done high only in cycle after edge k+14. Readback offsets 0..3 (start=0..3) -> count 1,2,8,3, each one cycle after the offset is applied.
REQ-030: Run default params, start=1 -> readback offset 26 gives 112, offset 0 gives 1, offset 255 (value 256) gives 9.
REQ-031: Run RAM_WORDS=4, start=0 -> offsets 0..3 give 0,1,2,8; S=12; done after edge k+12.
REQ-032: Pulse go every cycle during a run -> exactly one done pulse per run; results equal the single-go case.
REQ-033: Assert reset at edge k+5 mid-run -> done never pulses, count=0. A subsequent go with start=1 completes correctly.
REQ-034: Force a non-terminating value (e.g. modelled via a start that cycles under 32-bit wrap, or a forced iter near 16'hFFFF) -> 16'hFFFF stored, run proceeds to done.
